muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative HI/LO multiply/divide unit for a MIPS-style EX stage.
// mult/multu use 32 shift-add steps and div/divu use 32 restoring
// shift-subtract steps, followed by one sign-fix/write cycle.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   issue, R_Type      EX instruction valid / is R-type
//   func               instruction[5:0]
//   rs_val, rt_val     forwarded operands
//   flush              abort any in-flight operation
//   busy, stall        unit occupied / hold IF-ID-EX
//   mf_data            HI (mfhi) or LO (mflo), else 0
//   hi, lo             architectural HI/LO
// Optional build macro: MULDIV_EARLY_EXIT_EN (multiply leaves CALC once the
// remaining multiplier bits are zero).
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic        R_Type,
  input  logic [5:0]  func,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic        r_op_div, r_op_sgn, r_rs_neg, r_rt_neg, r_dz;
  logic [63:0] r_prod, r_mcand;
  logic [31:0] r_mplier, r_rem, r_quo, r_divisor;
  logic [31:0] r_hi, r_lo;

  logic        w_dec, w_is_mul, w_is_div, w_is_sgn;
  logic        w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  logic        w_start, w_calc_done;
  logic [31:0] w_rs_abs, w_rt_abs;
  logic [32:0] w_div_shift;
  logic [31:0] w_div_sub;
  logic        w_div_ok;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix, w_rem_fix;

  assign w_dec     = issue & R_Type;
  assign w_is_mul  = w_dec & ((func == 6'b011000) | (func == 6'b011001));
  assign w_is_div  = w_dec & ((func == 6'b011010) | (func == 6'b011011));
  assign w_is_sgn  = ~func[0];
  assign w_is_mfhi = w_dec & (func == 6'b010000);
  assign w_is_mthi = w_dec & (func == 6'b010001);
  assign w_is_mflo = w_dec & (func == 6'b010010);
  assign w_is_mtlo = w_dec & (func == 6'b010011);
  assign w_start   = (r_state == S_IDLE) & (w_is_mul | w_is_div) & ~flush;

  assign w_rs_abs = (w_is_sgn & rs_val[31]) ? -rs_val : rs_val;
  assign w_rt_abs = (w_is_sgn & rt_val[31]) ? -rt_val : rt_val;

  // Restoring step: the shifted partial remainder can reach 33 bits, but a
  // successful subtraction always leaves a result below the divisor.
  assign w_div_shift = {r_rem, r_quo[31]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_divisor});
  assign w_div_sub   = w_div_shift[31:0] - r_divisor;

  assign w_prod_fix = (r_op_sgn & (r_rs_neg ^ r_rt_neg)) ? -r_prod : r_prod;
  assign w_quo_fix  = (r_op_sgn & (r_rs_neg ^ r_rt_neg)) ? -r_quo : r_quo;
  assign w_rem_fix  = (r_op_sgn & r_rs_neg) ? -r_rem : r_rem;

`ifdef MULDIV_EARLY_EXIT_EN
  assign w_calc_done = (r_cnt == 6'd31) | (~r_op_div & (r_mplier[31:1] == '0));
`else
  assign w_calc_done = (r_cnt == 6'd31);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_CALC;
      S_CALC:  if (flush) w_next = S_IDLE;
               else if (w_calc_done) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    stall   = busy & (w_is_mul | w_is_div | w_is_mfhi | w_is_mflo | w_is_mthi | w_is_mtlo);
    mf_data = '0;
    if (w_is_mfhi)      mf_data = r_hi;
    else if (w_is_mflo) mf_data = r_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_op_sgn  <= 1'b0;
      r_rs_neg  <= 1'b0;
      r_rt_neg  <= 1'b0;
      r_dz      <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt     <= '0;
            r_op_div  <= w_is_div;
            r_op_sgn  <= w_is_sgn;
            r_rs_neg  <= rs_val[31];
            r_rt_neg  <= rt_val[31];
            r_dz      <= (rt_val == '0);
            r_prod    <= '0;
            r_mcand   <= {32'b0, w_rs_abs};
            r_mplier  <= w_rt_abs;
            r_rem     <= '0;
            r_quo     <= w_rs_abs;
            r_divisor <= w_rt_abs;
          end else begin
            if (w_is_mthi) r_hi <= rs_val;
            if (w_is_mtlo) r_lo <= rs_val;
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_op_div) begin
              r_rem <= w_div_ok ? w_div_sub : w_div_shift[31:0];
              r_quo <= {r_quo[30:0], w_div_ok};
            end else begin
              r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
            end
          end
        end
        S_FIX: begin
          // Divide by zero: the restoring loop already leaves rem = |rs|, so
          // the sign fix restores rs_val into HI; only LO needs forcing.
          if (!flush) begin
            if (r_op_div) begin
              r_hi <= w_rem_fix;
              r_lo <= r_dz ? '1 : w_quo_fix;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n, issue, R_Type, flush;
  logic [5:0]  func;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall;
  logic [31:0] mf_data, hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue),
    .R_Type  (R_Type),
    .func    (func),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .mf_data (mf_data),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tv[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue = 1'b0; R_Type = 1'b0; func = '0; rs_val = '0; rt_val = '0;
  endtask

  task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue = 1'b1; R_Type = 1'b1; func = f; rs_val = a; rt_val = b;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference result {HI,LO} straight from the arithmetic definition.
  function automatic logic [63:0] ref_hilo(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      F_MULT:  p = sa * sb;
      F_MULTU: p = {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb; r = sa % sb;
          qq = q; rr = r;
          p = {rr[31:0], qq[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          qq = {32'b0, a} / {32'b0, b};
          rr = {32'b0, a} % {32'b0, b};
          p = {rr[31:0], qq[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Number of cycles busy stays high after acceptance.
  function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
    int          bits;
    logic [31:0] m;
    bits = 32;
`ifdef MULDIV_EARLY_EXIT_EN
    if (f == F_MULT || f == F_MULTU) begin
      m = (f == F_MULT && b[31]) ? -b : b;
      bits = 1;
      for (int unsigned i = 0; i < 32; i++) if (m[i]) bits = int'(i) + 1;
    end
`else
    m = b;
    if (m[0] === 1'bx) bits = 32;
`endif
    return bits + 1;
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int n;
    present(f, a, b);
    tick();
    idle_in();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk($sformatf("%s busy_cycles", tag), 64'(n), 64'(exp_lat(f, b)));
    chk($sformatf("%s hi", tag), {32'b0, hi}, {32'b0, ehi});
    chk($sformatf("%s lo", tag), {32'b0, lo}, {32'b0, elo});
  endtask

  initial begin
    logic [63:0] r;
    logic [5:0]  f;
    logic [31:0] a, b;
    int          n, exp_n;
    logic [5:0]  ops [4];

    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

    tv[0] = '{F_MULTU, 32'hFFFFFFFF, 32'd2,         32'h00000001, 32'hFFFFFFFE};
    tv[1] = '{F_MULT,  32'hFFFFFFFD, 32'd7,         32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[2] = '{F_DIV,   32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3] = '{F_DIVU,  32'd9,        32'd0,         32'h00000009, 32'hFFFFFFFF};
    tv[4] = '{F_DIV,   32'd100,      32'hFFFFFFF9,  32'h00000002, 32'hFFFFFFF2};
    tv[5] = '{F_DIVU,  32'hFFFFFFFF, 32'd10,        32'h00000005, 32'h19999999};
    tv[6] = '{F_MULTU, 32'd5,        32'd1,         32'h00000000, 32'h00000005};
    tv[7] = '{F_DIV,   32'hFFFFFFF8, 32'd0,         32'hFFFFFFF8, 32'hFFFFFFFF};
    tv[8] = '{F_MULT,  32'h80000000, 32'h80000000,  32'h40000000, 32'h00000000};
    tv[9] = '{F_MULTU, 32'h12345678, 32'd0,         32'h00000000, 32'h00000000};

    idle_in();
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    present(F_MFHI, 32'h0, 32'h0);
    chk("reset busy",    {63'b0, busy},     64'd0);
    chk("reset stall",   {63'b0, stall},    64'd0);
    chk("reset hi",      {32'b0, hi},       64'd0);
    chk("reset lo",      {32'b0, lo},       64'd0);
    chk("reset mf_data", {32'b0, mf_data},  64'd0);
    idle_in();
    rst_n = 1'b1;
    tick();

    // Codes that must be ignored.
    present(6'b100000, 32'd3, 32'd4);
    tick();
    chk("ignore add busy", {63'b0, busy}, 64'd0);
    present(F_MULT, 32'd3, 32'd4);
    R_Type = 1'b0;
    tick();
    chk("ignore non-R busy", {63'b0, busy}, 64'd0);
    present(F_MTHI, 32'hDEAD, 32'd0);
    R_Type = 1'b0;
    tick();
    chk("ignore non-R mthi", {32'b0, hi}, 64'd0);

    // mthi / mtlo / mfhi / mflo.
    present(F_MTHI, 32'h00001234, 32'd0); tick();
    present(F_MTLO, 32'h00005678, 32'd0); tick();
    chk("mthi hi", {32'b0, hi}, 64'h1234);
    chk("mtlo lo", {32'b0, lo}, 64'h5678);
    present(F_MFHI, 32'd0, 32'd0); #1;
    chk("mfhi data", {32'b0, mf_data}, 64'h1234);
    present(F_MFLO, 32'd0, 32'd0); #1;
    chk("mflo data", {32'b0, mf_data}, 64'h5678);
    chk("mflo stall", {63'b0, stall}, 64'd0);
    idle_in(); #1;
    chk("no-op mf_data", {32'b0, mf_data}, 64'd0);
    tick();

    for (int unsigned i = 0; i < 10; i++)
      run_op(tv[i].f, tv[i].a, tv[i].b, tv[i].ehi, tv[i].elo, $sformatf("vec%0d", i));

    // mflo presented five cycles after a mult: stalls until the write.
    present(F_MULT, 32'hFFFFFFFD, 32'd7);
    tick();
    idle_in();
    repeat (4) tick();
    present(F_MFLO, 32'd0, 32'd0);
    n = 0;
    #1;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    exp_n = exp_lat(F_MULT, 32'd7) > 4 ? exp_lat(F_MULT, 32'd7) - 4 : 0;
    chk("mflo stall_cycles", 64'(n), 64'(exp_n));
    chk("mflo after stall data", {32'b0, mf_data}, 64'hFFFFFFEB);
    chk("mflo after stall stall", {63'b0, stall}, 64'd0);
    idle_in();
    tick();

    // Flush scenarios.
    present(F_MTHI, 32'h00001234, 32'd0); tick();
    present(F_MTLO, 32'h00005678, 32'd0); tick();
    present(F_MULT, 32'd11, 32'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    chk("flush at issue busy", {63'b0, busy}, 64'd0);

    present(F_MULTU, 32'h0000FFFF, 32'h0000FFFF);
    tick();
    idle_in();
    repeat (10) tick();
    chk("pre-flush calc busy", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush calc busy", {63'b0, busy}, 64'd0);
    chk("flush calc hi", {32'b0, hi}, 64'h1234);
    repeat (40) tick();
    chk("flush calc late hi", {32'b0, hi}, 64'h1234);
    chk("flush calc late lo", {32'b0, lo}, 64'h5678);

    present(F_DIVU, 32'd100, 32'd7);
    tick();
    idle_in();
    repeat (32) tick();
    chk("pre-flush fix busy", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush fix busy", {63'b0, busy}, 64'd0);
    chk("flush fix hi", {32'b0, hi}, 64'h1234);
    chk("flush fix lo", {32'b0, lo}, 64'h5678);

    // Randomised operations against the arithmetic model.
    for (int unsigned k = 0; k < 40; k++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 300);
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 1000);
      r = ref_hilo(f, a, b);
      run_op(f, a, b, r[63:32], r[31:0], $sformatf("rnd%0d f=%b a=%h b=%h", k, f, a, b));
    end

    // Reset in the middle of CALC discards the operation.
    present(F_MTHI, 32'h0000AAAA, 32'd0); tick();
    present(F_DIVU, 32'd1000, 32'd3);
    tick();
    idle_in();
    repeat (5) tick();
    present(F_MTLO, 32'h0000BBBB, 32'd0);
    flush = 1'b1;
    rst_n = 1'b0;
    tick();
    idle_in();
    flush = 1'b0;
    rst_n = 1'b1;
    chk("mid reset busy", {63'b0, busy}, 64'd0);
    chk("mid reset hi", {32'b0, hi}, 64'd0);
    chk("mid reset lo", {32'b0, lo}, 64'd0);
    repeat (40) tick();
    chk("post reset busy", {63'b0, busy}, 64'd0);
    chk("post reset lo", {32'b0, lo}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
